// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a parallel word as start, LSB-first data,
// optional parity and stop bits, one serial bit per clock.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  par_bit,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_q, par_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ovr_q, ovr_d;
  logic                  last_bit_c;

  assign last_bit_c = (idx_q == IDX_W'(DATA_WIDTH - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Data_Valid) state_d = START;
      START:   state_d = DATA;
      DATA:    if (last_bit_c) state_d = par_en_q ? PARITY : STOP;
      PARITY:  state_d = STOP;
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame context is captured once and then frozen against input changes.
  always_comb begin
    data_d   = data_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          data_d   = P_DATA;
          par_en_d = PAR_EN;
        end
      end
      START: begin
        par_d = par_bit;
        idx_d = '0;
      end
      DATA:    if (!last_bit_c) idx_d = idx_q + IDX_W'(1);
      default: ;
    endcase
  end

  // Outputs are precomputed from the next state so the line is registered.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP);
    ovr_d  = Data_Valid && (state_q != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_q[idx_d];
      PARITY:  tx_d = par_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q   <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      data_q   <= data_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  assign TX_OUT     = tx_q;
  assign Busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed frames plus random traffic, checked each
// cycle against a queue-of-line-bits frame model.
module tb_uart_tx_ctrl;

  localparam int unsigned DW = 8;

  logic          CLK;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          PAR_EN;
  logic          par_bit;
  logic          TX_OUT;
  logic          Busy;
  logic          frame_done;
  logic          overrun;

  int   checks;
  int   failures;
  bit   line_q[$];
  logic e_tx, e_busy, e_done, e_ovr;
  bit   scramble;
  bit   cap_en;
  logic [15:0] cap;
  int   cap_n, done_cnt, ovr_cnt, idle_cnt;

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .par_bit    (par_bit),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Even-parity calculator, frozen while Busy; optional noise after acceptance.
  always @(posedge CLK or negedge RST) begin
    if (!RST)                     par_bit <= 1'b0;
    else if (Data_Valid && !Busy) par_bit <= ^P_DATA;
    else if (scramble && Busy)    par_bit <= 1'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the reference: the line plays out a precomputed bit list.
  task automatic model_edge();
    e_ovr  = Data_Valid && (line_q.size() > 0);
    e_done = 1'b0;
    if (line_q.size() > 0) begin
      void'(line_q.pop_front());
      if (line_q.size() == 0) begin
        e_done = 1'b1;
        e_tx   = 1'b1;
        e_busy = 1'b0;
      end else begin
        e_tx   = line_q[0];
        e_busy = 1'b1;
      end
    end else if (Data_Valid) begin
      line_q.push_back(1'b0);
      for (int i = 0; i < int'(DW); i++) line_q.push_back(P_DATA[i]);
      if (PAR_EN) line_q.push_back(^P_DATA);
      line_q.push_back(1'b1);
      e_tx   = 1'b0;
      e_busy = 1'b1;
    end else begin
      e_tx   = 1'b1;
      e_busy = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    chk("tx_out",     32'(TX_OUT),     32'(e_tx));
    chk("busy",       32'(Busy),       32'(e_busy));
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("overrun",    32'(overrun),    32'(e_ovr));
    if (frame_done) done_cnt++;
    if (overrun)    ovr_cnt++;
    if (!Busy)      idle_cnt++;
    if (cap_en && Busy) begin
      cap = {cap[14:0], TX_OUT};
      cap_n++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [DW-1:0] d, input logic pen);
    P_DATA     = d;
    PAR_EN     = pen;
    Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0;
  endtask

  // Called just after an edge; pulses reset entirely between edges.
  task automatic do_reset(input string tag);
    #3 RST = 1'b0;
    #1;
    chk({tag, "_tx"},   32'(TX_OUT),     32'd1);
    chk({tag, "_busy"}, 32'(Busy),       32'd0);
    chk({tag, "_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_ovr"},  32'(overrun),    32'd0);
    line_q.delete();
    e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_ovr = 1'b0;
    #2 RST = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0;
    scramble = 1'b0; cap_en = 1'b0; cap = '0;
    cap_n = 0; done_cnt = 0; ovr_cnt = 0; idle_cnt = 0;
    RST = 1'b0; P_DATA = '0; Data_Valid = 1'b0; PAR_EN = 1'b0;
    e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_ovr = 1'b0;

    #12;
    chk("rst_tx",   32'(TX_OUT),     32'd1);
    chk("rst_busy", 32'(Busy),       32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_ovr",  32'(overrun),    32'd0);
    #1 RST = 1'b1;
    run(2);

    // 0xA5 with parity
    cap_en = 1'b1; cap = '0; cap_n = 0; done_cnt = 0;
    send(8'hA5, 1'b1);
    run(11);
    cap_en = 1'b0;
    chk("a5_bits",  32'(cap[10:0]), 32'(11'b01010010101));
    chk("a5_len",   32'(cap_n),     32'd11);
    chk("a5_done",  32'(done_cnt),  32'd1);

    // 0x3C without parity
    cap_en = 1'b1; cap = '0; cap_n = 0; done_cnt = 0;
    send(8'h3C, 1'b0);
    run(10);
    cap_en = 1'b0;
    chk("3c_bits",  32'(cap[9:0]),  32'(10'b0001111001));
    chk("3c_len",   32'(cap_n),     32'd10);
    chk("3c_done",  32'(done_cnt),  32'd1);

    // Data_Valid held through a 0x00 frame
    P_DATA = 8'h00; PAR_EN = 1'b1; Data_Valid = 1'b1;
    step();
    P_DATA = 8'hFF; ovr_cnt = 0;
    run(11);
    chk("hold_ovr_cnt", 32'(ovr_cnt), 32'd11);
    step();
    Data_Valid = 1'b0;
    chk("hold_ff_accept", 32'(Busy), 32'd1);
    run(12);

    // Data_Valid in START with flipped parity, plus noisy par_bit afterwards
    scramble = 1'b1;
    send(8'h01, 1'b1);
    P_DATA = 8'h03; Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0;
    run(11);

    // Reset at data index 4, then a clean frame
    done_cnt = 0;
    send(8'h5A, 1'b1);
    run(5);
    do_reset("midrst");
    run(3);
    chk("midrst_nodone", 32'(done_cnt), 32'd0);
    send(8'hC3, 1'b0);
    run(10);
    chk("postrst_done", 32'(done_cnt), 32'd1);

    // Back-to-back frames with Data_Valid held
    done_cnt = 0; idle_cnt = 0;
    P_DATA = 8'h01; PAR_EN = 1'b0; Data_Valid = 1'b1;
    step();
    P_DATA = 8'h80;
    run(10);
    step();
    Data_Valid = 1'b0;
    chk("b2b_gap", 32'(idle_cnt), 32'd1);
    run(10);
    chk("b2b_done", 32'(done_cnt), 32'd2);

    // Random traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      Data_Valid = ($urandom_range(0, 3) == 0);
      P_DATA     = DW'($urandom);
      PAR_EN     = 1'($urandom);
      step();
      if ($urandom_range(0, 499) == 0) do_reset("rnd_rst");
    end
    Data_Valid = 1'b0;
    run(15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
